// File: rtl/dfs_l1_metric_unit.sv
// L1 partial-distance responder for a 4-level depth-first sphere-style enumerator.
// Scores each presented node, gives a same-cycle prune hint and keeps the best full-depth leaf.
module dfs_l1_metric_unit #(
    parameter int WIDTH    = 20,
    parameter int COEF_W   = 8,
    parameter int METRIC_W = 24
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [WIDTH-1:0]       Y0,
    input  logic [WIDTH-1:0]       Y1,
    input  logic [WIDTH-1:0]       Y2,
    input  logic [WIDTH-1:0]       Y3,
    input  logic [10*COEF_W-1:0]   RFlat,
    input  logic                   NodeValid,
    input  logic [1:0]             NodeLvl,
    input  logic [2:0]             NodeSym0,
    input  logic [2:0]             NodeSym1,
    input  logic [2:0]             NodeSym2,
    input  logic [2:0]             NodeSym3,
    input  logic                   SearchDone,
    output logic                   GoDeeper,
    output logic [2:0]             BestSym0,
    output logic [2:0]             BestSym1,
    output logic [2:0]             BestSym2,
    output logic [2:0]             BestSym3,
    output logic [METRIC_W-1:0]    BestMetric,
    output logic                   BestFound,
    output logic                   ResultValid,
    output logic                   Busy
);

    localparam int PROD_W = COEF_W + 4;
    localparam int SUM_W  = COEF_W + 6;
    localparam int DIFF_W = ((WIDTH > SUM_W) ? WIDTH : SUM_W) + 1;
    localparam int EXT_W  = ((DIFF_W > METRIC_W) ? DIFF_W : METRIC_W) + 1;
    localparam logic [METRIC_W-1:0] METRIC_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

    state_t                state;
    logic [WIDTH-1:0]      y_q [4];
    logic [10*COEF_W-1:0]  r_q;
    logic [METRIC_W-1:0]   pd_q [1:3];
    logic [METRIC_W-1:0]   best_metric_q;
    logic [2:0]            best_sym_q [4];
    logic                  best_found_q;

    logic signed [3:0]         x [4];
    logic signed [COEF_W-1:0]  row [4];
    logic signed [PROD_W-1:0]  prod [4];
    logic signed [SUM_W-1:0]   dot;
    logic [WIDTH-1:0]          y_sel;
    logic signed [DIFF_W-1:0]  diff;
    logic [DIFF_W-1:0]         mag;
    logic [EXT_W-1:0]          mag_ext;
    logic [METRIC_W-1:0]       e_lvl;
    logic [METRIC_W-1:0]       parent;
    logic [METRIC_W:0]         metric_sum;
    logic [METRIC_W-1:0]       node_metric;
    logic                      better;

    function automatic logic signed [COEF_W-1:0] coef(input int k);
        return $signed(r_q[k*COEF_W +: COEF_W]);
    endfunction

    // Index i maps to x = 2i-7, which is just i with its MSB flipped and a trailing one.
    always_comb begin
        x[0] = {~NodeSym0[2], NodeSym0[1:0], 1'b1};
        x[1] = {~NodeSym1[2], NodeSym1[1:0], 1'b1};
        x[2] = {~NodeSym2[2], NodeSym2[1:0], 1'b1};
        x[3] = {~NodeSym3[2], NodeSym3[1:0], 1'b1};

        for (int j = 0; j < 4; j++) row[j] = '0;
        case (NodeLvl)
            2'd0: begin
                row[0] = coef(0);
                row[1] = coef(1);
                row[2] = coef(2);
                row[3] = coef(3);
            end
            2'd1: begin
                row[1] = coef(4);
                row[2] = coef(5);
                row[3] = coef(6);
            end
            2'd2: begin
                row[2] = coef(7);
                row[3] = coef(8);
            end
            default: row[3] = coef(9);
        endcase

        dot = '0;
        for (int j = 0; j < 4; j++) begin
            prod[j] = row[j] * x[j];
            dot     = dot + SUM_W'(prod[j]);
        end

        y_sel   = y_q[NodeLvl];
        diff    = DIFF_W'($signed(y_sel)) - DIFF_W'(dot);
        mag     = diff[DIFF_W-1] ? -diff : diff;
        mag_ext = EXT_W'(mag);
        e_lvl   = (mag_ext > EXT_W'(METRIC_MAX)) ? METRIC_MAX : mag_ext[METRIC_W-1:0];

        case (NodeLvl)
            2'd0:    parent = pd_q[1];
            2'd1:    parent = pd_q[2];
            2'd2:    parent = pd_q[3];
            default: parent = '0;
        endcase

        metric_sum  = {1'b0, parent} + {1'b0, e_lvl};
        node_metric = metric_sum[METRIC_W] ? METRIC_MAX : metric_sum[METRIC_W-1:0];
        better      = node_metric < best_metric_q;
    end

    assign GoDeeper    = (state == ST_SEARCH) && NodeValid && (NodeLvl != 2'd0) && better;
    assign Busy        = (state == ST_SEARCH);
    assign ResultValid = (state == ST_DONE);
    assign BestMetric  = best_metric_q;
    assign BestFound   = best_found_q;
    assign BestSym0    = best_sym_q[0];
    assign BestSym1    = best_sym_q[1];
    assign BestSym2    = best_sym_q[2];
    assign BestSym3    = best_sym_q[3];

    // Start has priority over everything; within SEARCH a node in the SearchDone cycle still counts.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            r_q           <= '0;
            best_metric_q <= METRIC_MAX;
            best_found_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i]        <= '0;
                best_sym_q[i] <= '0;
            end
            for (int i = 1; i <= 3; i++) pd_q[i] <= '0;
        end else if (Start) begin
            state         <= ST_SEARCH;
            y_q[0]        <= Y0;
            y_q[1]        <= Y1;
            y_q[2]        <= Y2;
            y_q[3]        <= Y3;
            r_q           <= RFlat;
            best_metric_q <= METRIC_MAX;
            best_found_q  <= 1'b0;
            for (int i = 1; i <= 3; i++) pd_q[i] <= '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (NodeValid) begin
                        case (NodeLvl)
                            2'd1: pd_q[1] <= node_metric;
                            2'd2: pd_q[2] <= node_metric;
                            2'd3: pd_q[3] <= node_metric;
                            default: begin
                                if (better) begin
                                    best_metric_q <= node_metric;
                                    best_found_q  <= 1'b1;
                                    best_sym_q[0] <= NodeSym0;
                                    best_sym_q[1] <= NodeSym1;
                                    best_sym_q[2] <= NodeSym2;
                                    best_sym_q[3] <= NodeSym3;
                                end
                            end
                        endcase
                    end
                    if (SearchDone) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
